chirp_ramp_gen: RTL and testbench

CHIRP_RAMP_GEN -- requirements
Module: chirp_ramp_gen

---
 rtl/chirp_ramp_gen_pkg.sv | 29 ++
 rtl/chirp_ramp_gen.sv | 150 +++++++++++++++
 tb/tb_chirp_ramp_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/chirp_ramp_gen_pkg.sv
// rtl/chirp_ramp_gen_pkg.sv - shared state encoding, bandwidth codes and step lookup
package chirp_ramp_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] BW_125K = 2'b00;
    localparam logic [1:0] BW_250K = 2'b01;
    localparam logic [1:0] BW_500K = 2'b10;
    localparam logic [1:0] BW_RSVD = 2'b11;

    localparam logic [15:0] STEP_125K = 16'd16;
    localparam logic [15:0] STEP_250K = 16'd32;
    localparam logic [15:0] STEP_500K = 16'd64;

    // Reserved code falls back to the narrowest bandwidth.
    function automatic logic [15:0] step_for_bw(input logic [1:0] bw);
        case (bw)
            BW_250K: return STEP_250K;
            BW_500K: return STEP_500K;
            default: return STEP_125K;
        endcase
    endfunction

endpackage

// File: rtl/chirp_ramp_gen.sv
// rtl/chirp_ramp_gen.sv - linear frequency ramp generator for chirp bursts
module chirp_ramp_gen #(
    parameter int STEPS_PER_CHIRP = 256,
    parameter int GAP_TICKS       = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_sample_tick_n,
    input  logic [1:0]  i_bw_config,
    input  logic [3:0]  i_num_chirps,
    output logic        o_tick_run,
    output logic [15:0] o_freq_word,
    output logic        o_valid,
    output logic [3:0]  o_chirp_idx,
    output logic        o_busy,
    output logic        o_done
);
    import chirp_ramp_gen_pkg::*;

    localparam logic [7:0]  LAST_K   = 8'(STEPS_PER_CHIRP - 1);
    localparam logic [15:0] LAST_GAP = 16'(GAP_TICKS - 1);

    state_t      state_q, state_d;
    logic [7:0]  sample_q, sample_d;
    logic [15:0] gap_q, gap_d;
    logic [3:0]  chirp_q, chirp_d;
    logic [3:0]  num_q, num_d;
    logic [1:0]  bw_q, bw_d;
    logic [15:0] freq_q, freq_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic tick;
    logic ramp_end;
    logic last_chirp;

    assign tick       = ~i_sample_tick_n;
    assign ramp_end   = tick && (sample_q == LAST_K);
    // num_q always holds the effective count (1..15), so this never underflows.
    assign last_chirp = (chirp_q == (num_q - 4'd1));

    // State register; synchronous reset wins over every other input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state selection; abort returns to IDLE from any busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start && !i_abort) state_d = ST_RAMP;
            ST_RAMP: begin
                if (i_abort)       state_d = ST_IDLE;
                else if (ramp_end) state_d = last_chirp ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                if (i_abort)                          state_d = ST_IDLE;
                else if (tick && (gap_q == LAST_GAP)) state_d = ST_RAMP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; words and strobes land one cycle after the tick.
    always_comb begin
        sample_d = sample_q;
        gap_d    = gap_q;
        chirp_d  = chirp_q;
        num_d    = num_q;
        bw_d     = bw_q;
        freq_d   = freq_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                freq_d   = 16'd0;
                chirp_d  = 4'd0;
                sample_d = 8'd0;
                gap_d    = 16'd0;
                if (i_start && !i_abort) begin
                    bw_d  = i_bw_config;
                    num_d = (i_num_chirps == 4'd0) ? 4'd1 : i_num_chirps;
                end
            end
            ST_RAMP: begin
                if (tick) begin
                    freq_d  = 16'(sample_q) * step_for_bw(bw_q);
                    valid_d = 1'b1;
                    if (ramp_end) begin
                        sample_d = 8'd0;
                        if (!last_chirp) chirp_d = chirp_q + 4'd1;
                    end else begin
                        sample_d = sample_q + 8'd1;
                    end
                end
            end
            ST_GAP: begin
                freq_d = 16'd0;
                if (tick) gap_d = (gap_q == LAST_GAP) ? 16'd0 : gap_q + 16'd1;
            end
            default: begin
                // Done is issued a cycle late so it never overlaps the final strobe.
                done_d = 1'b1;
                freq_d = 16'd0;
            end
        endcase
        if (i_abort && (state_q != ST_IDLE)) begin
            sample_d = 8'd0;
            gap_d    = 16'd0;
            chirp_d  = 4'd0;
            freq_d   = 16'd0;
            valid_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sample_q <= 8'd0;
            gap_q    <= 16'd0;
            chirp_q  <= 4'd0;
            num_q    <= 4'd1;
            bw_q     <= BW_125K;
            freq_q   <= 16'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            gap_q    <= gap_d;
            chirp_q  <= chirp_d;
            num_q    <= num_d;
            bw_q     <= bw_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_tick_run  = (state_q != ST_IDLE);
    assign o_freq_word = freq_q;
    assign o_valid     = valid_q;
    assign o_chirp_idx = chirp_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_chirp_ramp_gen.sv
// tb/tb_chirp_ramp_gen.sv - directed self-checking bench for chirp_ramp_gen
module tb_chirp_ramp_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        tick_n;
    logic [1:0]  bw;
    logic [3:0]  num;
    logic        tick_run;
    logic [15:0] freq;
    logic        valid;
    logic [3:0]  idx;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    chirp_ramp_gen #(.STEPS_PER_CHIRP(256), .GAP_TICKS(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_sample_tick_n(tick_n),
        .i_bw_config    (bw),
        .i_num_chirps   (num),
        .o_tick_run     (tick_run),
        .o_freq_word    (freq),
        .o_valid        (valid),
        .o_chirp_idx    (idx),
        .o_busy         (busy),
        .o_done         (done)
    );

    always @(posedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (valid === 1'b1 && done === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ramp_range(input int k0, input int k1, input logic [15:0] step,
                              input int spacing, output int good);
        good = 0;
        for (int k = k0; k <= k1; k++) begin
            tick_n = 1'b0;
            @(negedge clk);
            tick_n = 1'b1;
            if (valid === 1'b1 && freq === 16'(k) * step) good++;
            repeat (spacing - 1) @(negedge clk);
        end
    endtask

    task automatic gap_ticks(input int n, input int spacing, output int zero_ok);
        zero_ok = 0;
        for (int i = 0; i < n; i++) begin
            tick_n = 1'b0;
            @(negedge clk);
            tick_n = 1'b1;
            if (freq === 16'd0 && valid === 1'b0) zero_ok++;
            repeat (spacing - 1) @(negedge clk);
        end
    endtask

    initial begin
        int g, g2, z, v0, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tick_n = 1'b1;
        bw = 2'b00; num = 4'd0;
        cyc(3);
        check("rst_freq", freq, 0);
        check("rst_valid", valid, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tick_run", tick_run, 0);
        rst_n = 1'b1;
        cyc(1);

        // Ticks while idle are ignored.
        ramp_range(0, 2, 16'd16, 2, g);
        check("idle_ticks_good", g, 0);
        check("idle_ticks_valid", valid_cnt, 0);

        // bw=01, one chirp, tick every 40 clocks.
        bw = 2'b01; num = 4'd1;
        pulse_start();
        check("c1_busy", busy, 1);
        check("c1_tick_run", tick_run, 1);
        check("c1_idx", idx, 0);
        v0 = valid_cnt; d0 = done_cnt;
        ramp_range(0, 255, 16'd32, 40, g);
        cyc(3);
        check("c1_words", g, 256);
        check("c1_strobes", valid_cnt - v0, 256);
        check("c1_done", done_cnt - d0, 1);
        check("c1_busy_after", busy, 0);
        check("c1_freq_after", freq, 0);

        // bw=10, three chirps with 16-tick gaps.
        bw = 2'b10; num = 4'd3;
        pulse_start();
        d0 = done_cnt;
        for (int c = 0; c < 3; c++) begin
            check("c3_idx", idx, 32'(c));
            ramp_range(0, 254, 16'd64, 2, g);
            check("c3_words", g, 255);
            ramp_range(255, 255, 16'd64, 2, g);
            check("c3_last_word", g, 1);
            if (c < 2) begin
                v0 = valid_cnt;
                gap_ticks(16, 2, z);
                check("c3_gap_zero", z, 16);
                check("c3_gap_no_valid", valid_cnt - v0, 0);
                check("c3_gap_busy", busy, 1);
                check("c3_gap_idx", idx, 32'(c + 1));
            end
        end
        cyc(3);
        check("c3_done", done_cnt - d0, 1);
        check("c3_busy_after", busy, 0);

        // num_chirps=0 behaves as one chirp.
        bw = 2'b00; num = 4'd0;
        pulse_start();
        d0 = done_cnt; v0 = valid_cnt;
        ramp_range(0, 255, 16'd16, 1, g);
        cyc(3);
        check("n0_words", g, 256);
        check("n0_strobes", valid_cnt - v0, 256);
        check("n0_done", done_cnt - d0, 1);
        check("n0_busy_after", busy, 0);

        // Start and config changes while busy are ignored.
        bw = 2'b00; num = 4'd1;
        pulse_start();
        d0 = done_cnt;
        ramp_range(0, 49, 16'd16, 2, g);
        bw = 2'b10; num = 4'd5;
        pulse_start();
        ramp_range(50, 255, 16'd16, 2, g2);
        cyc(3);
        check("cfg_words", g + g2, 256);
        check("cfg_done", done_cnt - d0, 1);
        check("cfg_busy_after", busy, 0);

        // Abort at sample 100 of chirp 1.
        bw = 2'b01; num = 4'd2;
        pulse_start();
        ramp_range(0, 255, 16'd32, 1, g);
        gap_ticks(16, 1, z);
        check("ab_idx1", idx, 1);
        ramp_range(0, 99, 16'd32, 1, g);
        check("ab_words", g, 100);
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_tick_run", tick_run, 0);
        check("ab_freq", freq, 0);
        check("ab_valid", valid, 0);
        check("ab_idx", idx, 0);
        cyc(3);
        check("ab_no_done", done_cnt - d0, 0);
        bw = 2'b00; num = 4'd1;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("ab_start_tie", busy, 0);
        pulse_start();
        check("ab_restart_idx", idx, 0);
        ramp_range(0, 3, 16'd16, 1, g);
        check("ab_restart_words", g, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Reset mid-ramp.
        bw = 2'b01; num = 4'd1;
        pulse_start();
        ramp_range(0, 9, 16'd32, 1, g);
        check("rs_words", g, 10);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rs_freq", freq, 0);
        check("rs_valid", valid, 0);
        check("rs_idx", idx, 0);
        check("rs_busy", busy, 0);
        check("rs_tick_run", tick_run, 0);
        check("rs_done", done, 0);
        v0 = valid_cnt;
        ramp_range(0, 2, 16'd32, 2, g);
        cyc(2);
        check("rs_idle_ticks", valid_cnt - v0, 0);
        check("rs_no_done", done_cnt - d0, 0);
        check("never_valid_and_done", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
